// File: rtl/lbm_bank_pkg.sv
// lbm_bank_pkg: shared FSM states, default sizes and D2Q9 channel indices for the ping-pong bank
package lbm_bank_pkg;
  typedef enum logic [1:0] {IDLE, INIT, READY} state_t;
  localparam int Q_DEF = 9;
  localparam int DEPTH_DEF = 2500;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int C0 = 0;
  localparam int CN = 1;
  localparam int CNE = 2;
  localparam int CE = 3;
  localparam int CSE = 4;
  localparam int CS = 5;
  localparam int CSW = 6;
  localparam int CW = 7;
  localparam int CNW = 8;
endpackage

// File: rtl/lbm_bank_ram.sv
// lbm_bank_ram: single-port synchronous DEPTH x DATA_WIDTH RAM, read-or-write per cycle
module lbm_bank_ram #(
  parameter int DEPTH = 2500,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // one access per cycle: write when we, otherwise registered read
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= din;
      else dout <= mem[addr];
    end
endmodule

// File: rtl/lbm_pingpong_bank.sv
// lbm_pingpong_bank: double-buffered Q-channel LBM storage with fill, swap and host read (host port: LBM_BANK_HOST_EN)
module lbm_pingpong_bank
  import lbm_bank_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_start,
  input  logic [Q*DATA_WIDTH-1:0] init_val,
  output logic                    init_busy,
  output logic                    init_done,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [Q*DATA_WIDTH-1:0] rd_data,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [Q*DATA_WIDTH-1:0] wr_data,
  input  logic [Q-1:0]            wr_mask,
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic                    bank_sel,
  output logic [31:0]             frame_count,
  input  logic                    host_rd_en,
  input  logic [ADDR_WIDTH-1:0]   host_addr,
  output logic [Q*DATA_WIDTH-1:0] host_data,
  output logic                    host_valid,
  output logic                    host_busy
);
`ifdef LBM_BANK_HOST_EN
  localparam bit HOST_EN = 1'b1;
`else
  localparam bit HOST_EN = 1'b0;
`endif
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH-1);
  state_t state;
  logic [ADDR_WIDTH-1:0] fill_addr, host_addr_q, rport_addr;
  logic psel, rd_ok, host_ok;
  logic fill, rd_go, rd_in, host_go, host_in, rport_en, wport_en, accept, capture;
  logic [DATA_WIDTH-1:0] dout [2][Q];
  // read-bank port arbitration: fill, then solver read, then pending host read
  always_comb begin
    fill = state == INIT;
    rd_go = !fill && rd_en;
    rd_in = {1'b0, rd_addr} < LIMIT;
    host_go = HOST_EN && host_busy && !fill && !rd_en;
    host_in = {1'b0, host_addr_q} < LIMIT;
    rport_en = fill || (rd_go && rd_in) || (host_go && host_in);
    rport_addr = fill ? fill_addr : rd_go ? rd_addr : host_addr_q;
    wport_en = !fill && wr_en && {1'b0, wr_addr} < LIMIT;
    accept = state == READY && swap_req && !swap_ack && !host_busy;
    capture = HOST_EN && host_rd_en && !host_busy && !fill;
  end
  genvar b, k;
  generate
    for (b = 0; b < 2; b++) begin : g_bank
      logic is_rd;
      assign is_rd = bank_sel == 1'(b);
      for (k = 0; k < Q; k++) begin : g_ch
        lbm_bank_ram #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
          .clk  (clk),
          .en   (is_rd ? rport_en : wport_en && wr_mask[k]),
          .we   (!is_rd || fill),
          .addr (is_rd ? rport_addr : wr_addr),
          .din  (is_rd ? init_val[k*DATA_WIDTH +: DATA_WIDTH] : wr_data[k*DATA_WIDTH +: DATA_WIDTH]),
          .dout (dout[b][k])
        );
      end
    end
    for (k = 0; k < Q; k++) begin : g_out
      assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_ok ? dout[psel][k] : '0;
      assign host_data[k*DATA_WIDTH +: DATA_WIDTH] = host_ok ? dout[psel][k] : '0;
    end
  endgenerate
  // fill FSM: IDLE/READY -> INIT on init_start, INIT -> READY after the last address
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      fill_addr <= '0;
      init_busy <= 1'b0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b0;
      if (!fill && init_start) begin
        state <= INIT;
        fill_addr <= '0;
        init_busy <= 1'b1;
      end else if (fill) begin
        fill_addr <= fill_addr + 1'b1;
        if (fill_addr == LAST) begin
          state <= READY;
          init_busy <= 1'b0;
          init_done <= 1'b1;
        end
      end
    end
  // frame boundary: toggle banks and count completed swaps
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      swap_ack <= 1'b0;
      bank_sel <= 1'b0;
      frame_count <= '0;
    end else begin
      swap_ack <= accept;
      if (accept) begin
        bank_sel <= ~bank_sel;
        frame_count <= frame_count + 32'd1;
      end
    end
  // host capture/issue and read-data qualification; psel remembers which bank was read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      host_busy <= 1'b0;
      host_addr_q <= '0;
      host_valid <= 1'b0;
      host_ok <= 1'b0;
      rd_ok <= 1'b0;
      psel <= 1'b0;
    end else begin
      host_busy <= capture ? 1'b1 : host_go ? 1'b0 : host_busy;
      host_addr_q <= capture ? host_addr : host_addr_q;
      host_valid <= host_go;
      host_ok <= host_go && host_in;
      rd_ok <= rd_go && rd_in;
      psel <= bank_sel;
    end
endmodule

// File: tb/tb_lbm_pingpong_bank.sv
// tb_lbm_pingpong_bank: scoreboard bench for lbm_pingpong_bank (host tests under LBM_BANK_HOST_EN)
module tb_lbm_pingpong_bank;
  localparam int W = 144;
  logic clk, rst, init_start, init_busy, init_done, rd_en, wr_en, swap_req, swap_ack, bank_sel;
  logic host_rd_en, host_valid, host_busy;
  logic [W-1:0] init_val, rd_data, wr_data, host_data;
  logic [11:0] rd_addr, wr_addr, host_addr;
  logic [8:0] wr_mask;
  logic [31:0] frame_count;
  logic [W-1:0] rd_q[$], host_q[$];
  logic [W-1:0] mon_e, exp7, dd;
  logic prev_rd;
  int n_cmp, n_err, cyc, hv_cyc, busy_cnt, done_cnt;

  lbm_pingpong_bank dut (
    .clk(clk), .rst(rst), .init_start(init_start), .init_val(init_val), .init_busy(init_busy),
    .init_done(init_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .swap_req(swap_req), .swap_ack(swap_ack),
    .bank_sel(bank_sel), .frame_count(frame_count), .host_rd_en(host_rd_en), .host_addr(host_addr),
    .host_data(host_data), .host_valid(host_valid), .host_busy(host_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic logic [W-1:0] fillv(input logic [15:0] v);
    return {9{v}};
  endfunction

  function automatic logic [W-1:0] d1();
    logic [W-1:0] r;
    for (int i = 0; i < 9; i++) r[i*16 +: 16] = 16'h0A00 + 16'(i);
    return r;
  endfunction

  always @(negedge clk) begin
    if (prev_rd) begin
      if (rd_q.size() == 0) chk("rd_q_underflow", 144'(1), 144'(0));
      else begin
        mon_e = rd_q.pop_front();
        chk("rd_data", rd_data, mon_e);
      end
    end
    prev_rd <= rd_en;
    if (host_valid) begin
      hv_cyc <= cyc;
      if (host_q.size() == 0) chk("host_q_underflow", 144'(1), 144'(0));
      else begin
        mon_e = host_q.pop_front();
        chk("host_data", host_data, mon_e);
      end
    end
    busy_cnt <= busy_cnt + int'(init_busy);
    done_cnt <= done_cnt + int'(init_done);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [W-1:0] e);
    rd_en = 1'b1;
    rd_addr = a;
    rd_q.push_back(e);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [W-1:0] d, input logic [8:0] m);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_mask = m;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic swap();
    swap_req = 1'b1;
    for (int i = 0; i < 20 && !swap_ack; i++) tick();
    chk("swap_ack", 144'(swap_ack), 144'(1));
    swap_req = 1'b0;
  endtask

  initial begin
    int c0, c_ack;
    logic bad;
    n_cmp = 0; n_err = 0; cyc = 0; hv_cyc = 0; busy_cnt = 0; done_cnt = 0; prev_rd = 1'b0;
    rst = 1'b1; init_start = 1'b0; init_val = '0; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; wr_mask = '0; swap_req = 1'b0; host_rd_en = 1'b0; host_addr = '0;
    repeat (3) tick();
    chk("rst_rd_data", rd_data, '0);
    chk("rst_host_data", host_data, '0);
    chk("rst_frame_count", 144'(frame_count), 144'(0));
    chk("rst_flags", 144'({bank_sel, swap_ack, init_busy, init_done, host_busy, host_valid}), 144'(0));
    rst = 1'b0;
    tick();
    swap_req = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (swap_ack) bad = 1'b1;
    end
    swap_req = 1'b0;
    chk("idle_swap_ack", 144'(bad), 144'(0));
    chk("idle_frame_count", 144'(frame_count), 144'(0));
    init_val = fillv(16'h0E38);
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    chk("init_busy_rise", 144'(init_busy), 144'(1));
    for (int i = 0; i < 3000 && !init_done; i++) tick();
    chk("init_done_seen", 144'({init_done, init_busy}), 144'(2));
    tick();
    chk("init_busy_cycles", 144'(busy_cnt), 144'(2500));
    chk("init_done_pulses", 144'(done_cnt), 144'(1));
    rd(12'd0, fillv(16'h0E38));
    rd(12'd2499, fillv(16'h0E38));
    wr(12'd5, d1(), 9'h1FF);
    wr(12'd7, d1(), 9'h1FF);
    dd = {{8{16'hFFFF}}, 16'h1234};
    wr(12'd7, dd, 9'h001);
    rd(12'd7, fillv(16'h0E38));
    swap();
    tick();
    chk("frame_count_1", 144'(frame_count), 144'(1));
    chk("bank_sel_1", 144'(bank_sel), 144'(1));
    exp7 = d1();
    exp7[15:0] = 16'h1234;
    rd(12'd7, exp7);
`ifdef LBM_BANK_HOST_EN
    c0 = cyc;
    host_rd_en = 1'b1;
    host_addr = 12'd5;
    host_q.push_back(d1());
    tick();
    host_rd_en = 1'b0;
    rd_en = 1'b1;
    rd_addr = 12'd7;
    swap_req = 1'b1;
    repeat (3) begin
      rd_q.push_back(exp7);
      tick();
    end
    rd_en = 1'b0;
    for (int i = 0; i < 20 && !swap_ack; i++) tick();
    c_ack = cyc;
    swap_req = 1'b0;
    tick();
    chk("host_latency", 144'(hv_cyc - c0), 144'(5));
    chk("swap_ack_after_host", 144'(c_ack - c0), 144'(6));
`else
    host_rd_en = 1'b1;
    host_addr = 12'd5;
    tick();
    host_rd_en = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (host_valid || host_busy || (|host_data)) bad = 1'b1;
    end
    chk("host_disabled", 144'(bad), 144'(0));
    swap();
    tick();
`endif
    chk("frame_count_2", 144'(frame_count), 144'(2));
    chk("bank_sel_0", 144'(bank_sel), 144'(0));
    wr(12'd2500, d1(), 9'h1FF);
    rd(12'd3000, '0);
    rd(12'd2500, '0);
    rd(12'd0, fillv(16'h0E38));
    init_val = fillv(16'h0555);
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (1000) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("midinit_busy", 144'(init_busy), 144'(0));
    chk("midinit_no_done", 144'(done_cnt), 144'(1));
    rd(12'd999, fillv(16'h0555));
    rd(12'd1000, fillv(16'h0E38));
    rd(12'd1001, fillv(16'h0E38));
    repeat (3) tick();
    chk("queues_drained", 144'(rd_q.size() + host_q.size()), 144'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
